// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, transaction owner and
// starvation counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

  localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between fetch and load/store with a saturating starvation
// counter that forces a fetch grant after STARVE_LIMIT back-to-back data wins.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic if_valid_i,
  input  logic ls_valid_i,
  input  logic idle_i,
  output logic grant_if_o,
  output logic grant_ls_o
);

  localparam logic [STARVE_CNT_W-1:0] Limit = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    starved;

  always_comb begin
    starved      = (starve_cnt_q == Limit);
    grant_if_o   = idle_i && if_valid_i && (!ls_valid_i || starved);
    grant_ls_o   = idle_i && ls_valid_i && !grant_if_o;
    starve_cnt_d = starve_cnt_q;
    if (grant_if_o) begin
      starve_cnt_d = '0;
    end else if (grant_ls_o) begin
      // An LS grant while starved only happens with fetch idle, so it clears.
      if (!if_valid_i) begin
        starve_cnt_d = '0;
      end else if (!starved) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with a single outstanding
// transaction; responses are routed back to the owner, fetch responses can be flushed.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  input  logic                if_flush,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_req_we,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wstrb,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  output logic                busy
);

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                flushed_q, flushed_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                idle, grant_if, grant_ls;

  assign idle = (state_q == ARB_IDLE);

  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_valid_i(if_req_valid),
    .ls_valid_i(ls_req_valid),
    .idle_i    (idle),
    .grant_if_o(grant_if),
    .grant_ls_o(grant_ls)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    flushed_d    = flushed_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    ls_rsp_valid = 1'b0;
    ls_rsp_rdata = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_if || grant_ls) begin
          state_d   = ARB_ISSUE;
          owner_d   = grant_if ? OWN_IF : OWN_LS;
          we_d      = grant_ls && ls_req_we;
          addr_d    = grant_if ? if_req_addr : ls_req_addr;
          wdata_d   = grant_if ? '0 : ls_req_wdata;
          wstrb_d   = grant_if ? '0 : ls_req_wstrb;
          flushed_d = grant_if && if_flush;
        end
      end
      ARB_ISSUE: begin
        if (owner_q == OWN_IF && if_flush) flushed_d = 1'b1;
        if (mem_req_ready) state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (owner_q == OWN_IF && if_flush) flushed_d = 1'b1;
        // Route on the registered flag: a flush in the response cycle is too late.
        if (owner_q == OWN_IF) begin
          if_rsp_valid = mem_rsp_valid && !flushed_q;
          if_rsp_data  = mem_rsp_rdata;
        end else begin
          ls_rsp_valid = mem_rsp_valid;
          ls_rsp_rdata = we_q ? '0 : mem_rsp_rdata;
        end
        if (mem_rsp_valid) begin
          state_d   = ARB_IDLE;
          flushed_d = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_IF;
      flushed_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      flushed_q <= flushed_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;
  assign mem_req_valid = (state_q == ARB_ISSUE);
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;
  assign busy          = !idle;

endmodule
